// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle MIPS instruction fetch stage.
// Owns the architectural PC, drives a valid/ready instruction-memory port
// and presents one fetched instruction at a time to the IF/ID boundary.
// Honours branch delay slots, exception entry, ERET return and stall.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] npc_in,
    input  logic        redirect,
    input  logic        stall,
    input  logic        flush,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_adel
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [31:0] pend_addr, pend_addr_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;
    logic        valid_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] ifpc_nxt;
    logic        adel_nxt;

    logic        take_exc;
    logic [31:0] exc_target;
    logic        misaligned;

    // Exception entry beats ERET; both beat any redirect or sequential step.
    assign take_exc   = flush | eret;
    assign exc_target = flush ? EXC_VEC : epc;
    assign misaligned = (pc[1:0] != 2'b00);

    // A request is raised only for aligned fetches, and is kept up in DRAIN
    // at the old address so an accepted-but-unanswered request is never withdrawn.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        if (state == DRAIN) begin
            imem_req  = 1'b1;
            imem_addr = drain_addr;
        end else if (state == FETCH) begin
            imem_req  = ~misaligned;
        end
    end

    // Next-state and next-register logic for the fetch sequencer.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_valid_nxt = pend_valid;
        pend_addr_nxt  = pend_addr;
        drain_addr_nxt = drain_addr;
        valid_nxt      = if_valid;
        instr_nxt      = if_instr;
        ifpc_nxt       = if_pc;
        adel_nxt       = if_adel;

        case (state)
            BOOT: begin
                state_nxt = FETCH;
                if (take_exc) begin
                    pc_nxt         = exc_target;
                    pend_valid_nxt = 1'b0;
                    valid_nxt      = 1'b0;
                end else if (redirect) begin
                    pend_addr_nxt  = npc_in;
                    pend_valid_nxt = 1'b1;
                end
            end

            FETCH: begin
                if (take_exc) begin
                    pc_nxt         = exc_target;
                    pend_valid_nxt = 1'b0;
                    valid_nxt      = 1'b0;
                    if (!misaligned && !imem_ready) begin
                        state_nxt      = DRAIN;
                        drain_addr_nxt = pc;
                    end else begin
                        state_nxt = FETCH;
                    end
                end else begin
                    if (redirect) begin
                        pend_addr_nxt  = npc_in;
                        pend_valid_nxt = 1'b1;
                    end
                    if (misaligned) begin
                        instr_nxt = 32'h0;
                        ifpc_nxt  = pc;
                        adel_nxt  = 1'b1;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end else if (imem_ready) begin
                        instr_nxt = imem_rdata;
                        ifpc_nxt  = pc;
                        adel_nxt  = 1'b0;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end

            HOLD: begin
                if (take_exc) begin
                    pc_nxt         = exc_target;
                    pend_valid_nxt = 1'b0;
                    valid_nxt      = 1'b0;
                    state_nxt      = FETCH;
                end else if (!stall) begin
                    if (redirect) begin
                        pc_nxt = npc_in;
                    end else if (pend_valid) begin
                        pc_nxt = pend_addr;
                    end else begin
                        pc_nxt = pc + 32'd4;
                    end
                    pend_valid_nxt = 1'b0;
                    valid_nxt      = 1'b0;
                    state_nxt      = FETCH;
                end else if (redirect) begin
                    pend_addr_nxt  = npc_in;
                    pend_valid_nxt = 1'b1;
                end
            end

            DRAIN: begin
                if (take_exc) begin
                    pc_nxt         = exc_target;
                    pend_valid_nxt = 1'b0;
                    valid_nxt      = 1'b0;
                end else if (redirect) begin
                    pend_addr_nxt  = npc_in;
                    pend_valid_nxt = 1'b1;
                end
                if (imem_ready) begin
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_addr  <= 32'h0;
            drain_addr <= 32'h0;
            if_valid   <= 1'b0;
            if_instr   <= 32'h0;
            if_pc      <= 32'h0;
            if_adel    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend_valid <= pend_valid_nxt;
            pend_addr  <= pend_addr_nxt;
            drain_addr <= drain_addr_nxt;
            if_valid   <= valid_nxt;
            if_instr   <= instr_nxt;
            if_pc      <= ifpc_nxt;
            if_adel    <= adel_nxt;
        end
    end

endmodule
